// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: blank/show sequencing per digit,
// frame-boundary commit of pending data, and leading-zero blanking.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 12500,
  parameter int BLANK  = 250
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEn,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic                  iLzb,
  output logic [3:0]            oNibble,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(MAXC);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  pend_q, pend_d;
  logic [DIGITS-1:0][3:0]  disp_q, disp_d;
  logic                    pend_v_q, pend_v_d;
  logic [3:0]              nib_q, nib_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    frame_q, frame_d;
  logic                    wrap;
  logic [DIGITS-1:0]       zero_up;
  logic                    supp;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    frame_d  = 1'b0;
    wrap     = 1'b0;
    if (iEn) begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == CW'(BLANK-1)) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CW'(DIV-1)) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IW'(DIGITS-1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
    // Commit reads the old pend; a same-edge load re-arms pend for the next frame.
    if (wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
      frame_d  = 1'b1;
    end
    if (iLoad) begin
      pend_d   = iData;
      pend_v_d = 1'b1;
    end
  end

  // zero_up[i]: digits i..DIGITS-1 of the (next) display value are all zero
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign zero_up[i] = (disp_d[DIGITS-1:i] == '0);
  end

  always_comb begin
    supp  = iLzb && (idx_d != '0) && zero_up[idx_d];
    nib_d = iEn ? disp_d[idx_d] : nib_q;
    an_d  = '1;
    if (iEn && (state_d == S_SHOW) && !supp) an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      nib_q    <= 4'h0;
      an_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign oNibble = nib_q;
  assign oAn     = an_q;
  assign oFrame  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: timeline model of the scan checked every cycle,
// plus directed literal expectations along a scripted scenario.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int D = 4, DV = 8, BL = 2;
  localparam int SLOT = BL + DV, FRAME = D * SLOT;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, lzb = 1'b0;
  logic [4*D-1:0] data = '0;
  logic [3:0] nib;
  logic [D-1:0] an;
  logic frame;

  int pass_cnt = 0, tot_cnt = 0, k = 0;
  bit go = 1'b0;

  seg_scan_ctrl #(.DIGITS(D), .DIV(DV), .BLANK(BL)) dut (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLoad(load), .iData(data),
    .iLzb(lzb), .oNibble(nib), .oAn(an), .oFrame(frame));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", nm, got, exp, k, $time);
  endtask

  // Model: position in the frame is just the count of enabled edges mod frame length.
  int t;
  logic [15:0] m_disp, m_pend;
  bit m_pv, m_frame;
  logic [3:0] m_nib, m_an;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_nib = 4'h0; m_an = 4'hF; m_frame = 0;
    end else begin
      int dig, ph;
      m_frame = 0;
      if (en) begin
        t = (t + 1) % FRAME;
        if (t == 0 && m_pv) begin m_disp = m_pend; m_pv = 0; m_frame = 1; end
      end
      if (load) begin m_pend = data; m_pv = 1; end
      m_an = 4'hF;
      if (en) begin
        dig = t / SLOT;
        ph  = t % SLOT;
        m_nib = m_disp[dig*4 +: 4];
        if (ph >= BL && !(lzb && dig > 0 && (m_disp >> (4*dig)) == 16'h0)) m_an[dig] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (go) begin
    chk("model_an", 32'(an), 32'(m_an));
    chk("model_nib", 32'(nib), 32'(m_nib));
    chk("model_frame", 32'(frame), 32'(m_frame));
  end

  task automatic tick();
    @(posedge clk); #1; k++;
  endtask

  task automatic run_to(input int kk);
    while (k < kk) tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; go = 1'b1;
    chk("rst_an", 32'(an), 'hF);
    chk("rst_nib", 32'(nib), 'h0);
    chk("rst_frame", 32'(frame), 'h0);
    rst_n = 1'b1; en = 1'b1; k = 0;
    // Plain scan
    while (k < 42) begin
      tick();
      case (k)
        1:  chk("scan_k1", 32'(an), 'hF);
        2:  chk("scan_k2", 32'(an), 'hE);
        9:  chk("scan_k9", 32'(an), 'hE);
        10: chk("scan_k10", 32'(an), 'hF);
        12: chk("scan_k12", 32'(an), 'hD);
        22: chk("scan_k22", 32'(an), 'hB);
        39: chk("scan_k39", 32'(an), 'h7);
        40: chk("scan_k40", 32'(an), 'hF);
        42: chk("scan_k42", 32'(an), 'hE);
        default: ;
      endcase
    end
    // Load mid-frame, commit at next wrap (k=80)
    load = 1'b1; data = 16'h1234; tick(); load = 1'b0;
    run_to(79);
    chk("pre_commit_frame", 32'(frame), 'h0);
    chk("pre_commit_nib", 32'(nib), 'h0);
    tick();
    chk("commit_frame", 32'(frame), 'h1);
    chk("commit_nib0", 32'(nib), 'h4);
    tick();
    chk("commit_frame_1cyc", 32'(frame), 'h0);
    run_to(92);  chk("nib1", 32'(nib), 'h3); chk("an1", 32'(an), 'hD);
    run_to(102); chk("nib2", 32'(nib), 'h2);
    run_to(112); chk("nib3", 32'(nib), 'h1); chk("an3", 32'(an), 'h7);
    // Collision: second load lands on the wrap edge (k=120)
    run_to(114); load = 1'b1; data = 16'h9876; tick(); load = 1'b0;
    run_to(119); load = 1'b1; data = 16'h0005; tick(); load = 1'b0;
    chk("coll_frame", 32'(frame), 'h1);
    chk("coll_nib0", 32'(nib), 'h6);
    run_to(132); chk("coll_nib1", 32'(nib), 'h7);
    run_to(152); chk("coll_nib3", 32'(nib), 'h9);
    run_to(160); chk("coll_frame2", 32'(frame), 'h1); chk("coll_nib_new", 32'(nib), 'h5);
    // Leading-zero blanking
    lzb = 1'b1;
    run_to(162); chk("lzb_d0", 32'(an), 'hE);
    run_to(164); load = 1'b1; data = 16'h0000; tick(); load = 1'b0;
    run_to(172); chk("lzb_d1", 32'(an), 'hF);
    run_to(182); chk("lzb_d2", 32'(an), 'hF);
    run_to(192); chk("lzb_d3", 32'(an), 'hF);
    run_to(200); chk("zero_frame", 32'(frame), 'h1);
    run_to(202); chk("zero_d0_an", 32'(an), 'hE); chk("zero_d0_nib", 32'(nib), 'h0);
    run_to(212); chk("zero_d1_an", 32'(an), 'hF);
    run_to(214); lzb = 1'b0;
    tick();      chk("nolzb_d1", 32'(an), 'hD);
    run_to(222); chk("nolzb_d2", 32'(an), 'hB);
    run_to(232); chk("nolzb_d3", 32'(an), 'h7);
    // Enable freeze during digit 2 show, with a load accepted while frozen
    run_to(264); en = 1'b0;
    tick();      chk("dis_an", 32'(an), 'hF);
    load = 1'b1; data = 16'h4321; tick(); load = 1'b0;
    chk("dis_an2", 32'(an), 'hF);
    run_to(269); en = 1'b1;
    tick();      chk("resume_an", 32'(an), 'hB);
    run_to(274); chk("resume_last", 32'(an), 'hB);
    tick();      chk("resume_blank", 32'(an), 'hF);
    run_to(277); chk("resume_d3", 32'(an), 'h7);
    run_to(285); chk("dis_load_frame", 32'(frame), 'h1); chk("dis_load_nib", 32'(nib), 'h1);
    run_to(288); chk("pre_rst_an", 32'(an), 'hE);
    // Async reset mid-show
    rst_n = 1'b0; #1;
    chk("arst_an", 32'(an), 'hF);
    chk("arst_nib", 32'(nib), 'h0);
    chk("arst_frame", 32'(frame), 'h0);
    run_to(290); rst_n = 1'b1;
    tick(); chk("rel_k1", 32'(an), 'hF);
    tick(); chk("rel_k2_an", 32'(an), 'hE); chk("rel_k2_nib", 32'(nib), 'h0);
    repeat (10) tick();
    go = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
